// File: rtl/riscv_lsu.sv
// Load-store unit between the core data port and a word-addressed data memory.
// Generates byte enables and replicated store data, extends load data, holds
// the core for the memory's one-cycle read latency, flags misaligned or
// illegal-size accesses and raises a bus error when memory never answers.
//
// Handshake: the core holds core_req_i and all operands stable while
// core_stall_o is high. An access is accepted in IDLE and completes in WAIT
// on the first cycle with mem_ready_i=1 (core_stall_o drops, core_rd_o is
// valid in that same cycle). A misaligned request is rejected in the cycle it
// is presented (misalign_o=1, no stall, no memory request).
module riscv_lsu #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        misalign_o,
  output logic        bus_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i,
  output logic        dbg_wait_o
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  state_e        state_q;
  logic [TW-1:0] tmo_q;

  logic        is_byte;
  logic        is_half;
  logic        is_word;
  logic        is_unsigned;
  logic        size_bad;
  logic        misalign;
  logic        valid;
  logic        in_wait;
  logic        ack;
  logic        tmo_hit;
  logic [1:0]  offs;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] rd_ext;

  assign offs = core_addr_i[1:0];

  // Decode the access size and detect misaligned or illegal requests.
  always_comb begin
    is_byte     = (core_size_i[1:0] == 2'b00);
    is_half     = (core_size_i[1:0] == 2'b01);
    is_word     = (core_size_i == 3'b010);
    is_unsigned = core_size_i[2];
    size_bad    = (core_size_i[1:0] == 2'b11) || (core_size_i == 3'b110);
    misalign    = core_req_i &&
                  (size_bad ||
                   (is_half && offs[0]) ||
                   (is_word && (offs != 2'b00)));
  end

  assign valid   = core_req_i & ~misalign;
  // While reset is held the unit behaves as if it were idle.
  assign in_wait = (state_q == S_WAIT) & ~rst_i;
  assign ack     = in_wait & valid & mem_ready_i;
  assign tmo_hit = in_wait & valid & ~mem_ready_i & (tmo_q == TMO_LAST);

  // Core-side status: stall on acceptance and while waiting for memory.
  always_comb begin
    core_stall_o = 1'b0;
    if (in_wait) begin
      core_stall_o = valid & ~mem_ready_i & ~tmo_hit;
    end else begin
      core_stall_o = valid;
    end
    misalign_o = misalign;
    bus_err_o  = tmo_hit;
    dbg_wait_o = (state_q == S_WAIT);
  end

  // Memory request, byte enables and replicated store data.
  always_comb begin
    mem_req_o  = valid;
    mem_we_o   = valid & core_we_i;
    mem_addr_o = core_addr_i;
    mem_be_o   = 4'b0000;
    if (valid) begin
      if (is_byte) begin
        mem_be_o = 4'b0001 << offs;
      end else if (is_half) begin
        mem_be_o = offs[1] ? 4'b1100 : 4'b0011;
      end else begin
        mem_be_o = 4'b1111;
      end
    end
    case (core_size_i[1:0])
      2'b00:   mem_wd_o = {4{core_wd_i[7:0]}};
      2'b01:   mem_wd_o = {2{core_wd_i[15:0]}};
      default: mem_wd_o = core_wd_i;
    endcase
  end

  // Lane selection and sign/zero extension of load data.
  always_comb begin
    case (offs)
      2'b00:   rd_byte = mem_rd_i[7:0];
      2'b01:   rd_byte = mem_rd_i[15:8];
      2'b10:   rd_byte = mem_rd_i[23:16];
      default: rd_byte = mem_rd_i[31:24];
    endcase
    rd_half = offs[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];
    if (is_byte) begin
      rd_ext = {{24{rd_byte[7] & ~is_unsigned}}, rd_byte};
    end else if (is_half) begin
      rd_ext = {{16{rd_half[15] & ~is_unsigned}}, rd_half};
    end else begin
      rd_ext = mem_rd_i;
    end
    core_rd_o = ack ? rd_ext : 32'h0;
  end

  // Access FSM: IDLE accepts a request, WAIT holds it until ready/timeout.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      tmo_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (valid) begin
            state_q <= S_WAIT;
            tmo_q   <= '0;
          end
        end
        S_WAIT: begin
          // Ready, timeout, or the core dropping its request all end the access.
          if (!valid || mem_ready_i || (tmo_q == TMO_LAST)) begin
            state_q <= S_IDLE;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed bench for riscv_lsu with TIMEOUT=4: a table of single accesses
// plus hand-written sequences for timeout, reset and back-to-back traffic.
module tb_riscv_lsu;

  logic        clk;
  logic        rst;
  logic        core_req;
  logic        core_we;
  logic [2:0]  core_size;
  logic [31:0] core_addr;
  logic [31:0] core_wd;
  logic [31:0] core_rd;
  logic        core_stall;
  logic        misalign;
  logic        bus_err;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;
  logic        mem_ready;
  logic        dbg_wait;

  int checks;
  int failures;

  riscv_lsu #(.TIMEOUT(4)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .core_req_i   (core_req),
    .core_we_i    (core_we),
    .core_size_i  (core_size),
    .core_addr_i  (core_addr),
    .core_wd_i    (core_wd),
    .core_rd_o    (core_rd),
    .core_stall_o (core_stall),
    .misalign_o   (misalign),
    .bus_err_o    (bus_err),
    .mem_req_o    (mem_req),
    .mem_we_o     (mem_we),
    .mem_be_o     (mem_be),
    .mem_addr_o   (mem_addr),
    .mem_wd_o     (mem_wd),
    .mem_rd_i     (mem_rd),
    .mem_ready_i  (mem_ready),
    .dbg_wait_o   (dbg_wait)
  );

  // Clock and reset defaults
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] word;
    logic        exp_mis;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic we, input logic [2:0] size,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input logic [31:0] word, input logic exp_mis,
                              input logic [3:0] exp_be, input logic [31:0] exp_wd,
                              input logic [31:0] exp_rd);
    vec_t v;
    v.we = we; v.size = size; v.addr = addr; v.wd = wd; v.word = word;
    v.exp_mis = exp_mis; v.exp_be = exp_be; v.exp_wd = exp_wd; v.exp_rd = exp_rd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [2:0] size,
                       input logic [31:0] addr, input logic [31:0] wd);
    core_req  = 1'b1;
    core_we   = we;
    core_size = size;
    core_addr = addr;
    core_wd   = wd;
  endtask

  task automatic idle_core();
    core_req  = 1'b0;
    core_we   = 1'b0;
    mem_ready = 1'b0;
  endtask

  task automatic run_vec(input int i, input vec_t v);
    string t;
    t = $sformatf("v%0d", i);
    drive(v.we, v.size, v.addr, v.wd);
    @(negedge clk);
    chk({t, "_mis"}, 32'(misalign), 32'(v.exp_mis));
    chk({t, "_req"}, 32'(mem_req), 32'(!v.exp_mis));
    chk({t, "_stall1"}, 32'(core_stall), 32'(!v.exp_mis));
    chk({t, "_be1"}, 32'(mem_be), 32'(v.exp_be));
    chk({t, "_we1"}, 32'(mem_we), 32'(v.we && !v.exp_mis));
    if (v.we) chk({t, "_wd"}, mem_wd, v.exp_wd);
    if (!v.exp_mis) chk({t, "_addr"}, mem_addr, v.addr);
    step();
    if (v.exp_mis) begin
      chk({t, "_stay_idle"}, 32'(dbg_wait), 32'd0);
      idle_core();
    end else begin
      chk({t, "_in_wait"}, 32'(dbg_wait), 32'd1);
      mem_rd    = v.word;
      mem_ready = 1'b1;
      @(negedge clk);
      chk({t, "_stall2"}, 32'(core_stall), 32'd0);
      chk({t, "_req2"}, 32'(mem_req), 32'd1);
      chk({t, "_we2"}, 32'(mem_we), 32'(v.we));
      chk({t, "_be2"}, 32'(mem_be), 32'(v.exp_be));
      chk({t, "_rd"}, core_rd, v.exp_rd);
      step();
      idle_core();
      chk({t, "_back_idle"}, 32'(dbg_wait), 32'd0);
    end
    step();
  endtask

  initial begin
    int stalls;
    bit seen;
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    core_req  = 1'b0;
    core_we   = 1'b0;
    core_size = 3'd2;
    core_addr = 32'h0;
    core_wd   = 32'h0;
    mem_rd    = 32'h0;
    mem_ready = 1'b0;

    // Vector table: we size addr wd word | mis be wd rd
    vecs.push_back(mk(0, 3'd2, 32'h10, 32'h0, 32'hDEADBEEF, 0, 4'b1111, 32'h0, 32'hDEADBEEF));
    vecs.push_back(mk(0, 3'd0, 32'h13, 32'h0, 32'h80FF0102, 0, 4'b1000, 32'h0, 32'hFFFFFF80));
    vecs.push_back(mk(0, 3'd4, 32'h13, 32'h0, 32'h80FF0102, 0, 4'b1000, 32'h0, 32'h00000080));
    vecs.push_back(mk(0, 3'd5, 32'h12, 32'h0, 32'h80FF0102, 0, 4'b1100, 32'h0, 32'h000080FF));
    vecs.push_back(mk(0, 3'd1, 32'h12, 32'h0, 32'h80FF0102, 0, 4'b1100, 32'h0, 32'hFFFF80FF));
    vecs.push_back(mk(0, 3'd0, 32'h11, 32'h0, 32'h80FF0102, 0, 4'b0010, 32'h0, 32'h00000001));
    vecs.push_back(mk(0, 3'd5, 32'h10, 32'h0, 32'h80FF0102, 0, 4'b0011, 32'h0, 32'h00000102));
    vecs.push_back(mk(0, 3'd0, 32'h12, 32'h0, 32'h007F0000, 0, 4'b0100, 32'h0, 32'h0000007F));
    vecs.push_back(mk(1, 3'd0, 32'h21, 32'h000000AB, 32'h0, 0, 4'b0010, 32'hABABABAB, 32'h0));
    vecs.push_back(mk(1, 3'd1, 32'h22, 32'h00001234, 32'h0, 0, 4'b1100, 32'h12341234, 32'h0));
    vecs.push_back(mk(1, 3'd2, 32'h24, 32'hCAFEF00D, 32'h0, 0, 4'b1111, 32'hCAFEF00D, 32'h0));
    vecs.push_back(mk(0, 3'd2, 32'h06, 32'h0, 32'h0, 1, 4'b0000, 32'h0, 32'h0));
    vecs.push_back(mk(0, 3'd3, 32'h10, 32'h0, 32'h0, 1, 4'b0000, 32'h0, 32'h0));
    vecs.push_back(mk(0, 3'd1, 32'h11, 32'h0, 32'h0, 1, 4'b0000, 32'h0, 32'h0));
    vecs.push_back(mk(1, 3'd5, 32'h13, 32'h0, 32'h0, 1, 4'b0000, 32'h0, 32'h0));
    vecs.push_back(mk(1, 3'd6, 32'h10, 32'h0, 32'h0, 1, 4'b0000, 32'h0, 32'h0));
    vecs.push_back(mk(0, 3'd7, 32'h10, 32'h0, 32'h0, 1, 4'b0000, 32'h0, 32'h0));

    // Reset state with no request
    step();
    @(negedge clk);
    chk("rst_stall", 32'(core_stall), 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_be", 32'(mem_be), 32'd0);
    chk("rst_rd", core_rd, 32'd0);
    step();
    rst = 1'b0;
    chk("rst_idle", 32'(dbg_wait), 32'd0);
    step();

    for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);

    // Timeout: ready held low
    drive(0, 3'd2, 32'h40, 32'h0);
    mem_ready = 1'b0;
    stalls = 0;
    seen   = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus_err) begin
        seen = 1;
        chk("tmo_rd", core_rd, 32'd0);
        chk("tmo_stall", 32'(core_stall), 32'd0);
        break;
      end
      if (core_stall) stalls++;
      step();
    end
    chk("tmo_seen", 32'(seen), 32'd1);
    chk("tmo_stall_cycles", stalls, 32'd4);
    step();
    idle_core();
    chk("tmo_back_idle", 32'(dbg_wait), 32'd0);
    @(negedge clk);
    chk("tmo_pulse_end", 32'(bus_err), 32'd0);
    step();

    // Ready arriving on the last-but-one wait cycle must not time out
    drive(0, 3'd2, 32'h44, 32'h0);
    step();
    step();
    step();
    mem_rd    = 32'h11223344;
    mem_ready = 1'b1;
    @(negedge clk);
    chk("late_bus_err", 32'(bus_err), 32'd0);
    chk("late_stall", 32'(core_stall), 32'd0);
    chk("late_rd", core_rd, 32'h11223344);
    step();
    idle_core();
    step();

    // Reset asserted during WAIT
    drive(0, 3'd2, 32'h50, 32'h0);
    step();
    chk("rstw_in_wait", 32'(dbg_wait), 32'd1);
    rst       = 1'b1;
    mem_ready = 1'b1;
    mem_rd    = 32'hFFFFFFFF;
    @(negedge clk);
    chk("rstw_stall", 32'(core_stall), 32'd1);
    chk("rstw_bus_err", 32'(bus_err), 32'd0);
    chk("rstw_rd", core_rd, 32'd0);
    step();
    chk("rstw_idle", 32'(dbg_wait), 32'd0);
    rst = 1'b0;
    idle_core();
    step();

    // Back-to-back SW then LW
    drive(1, 3'd2, 32'h30, 32'h55AA55AA);
    @(negedge clk);
    chk("b2b_sw_stall1", 32'(core_stall), 32'd1);
    chk("b2b_sw_we1", 32'(mem_we), 32'd1);
    step();
    mem_ready = 1'b1;
    @(negedge clk);
    chk("b2b_sw_stall2", 32'(core_stall), 32'd0);
    chk("b2b_sw_we2", 32'(mem_we), 32'd1);
    step();
    drive(0, 3'd2, 32'h30, 32'h0);
    mem_ready = 1'b0;
    mem_rd    = 32'h0;
    @(negedge clk);
    chk("b2b_lw_idle", 32'(dbg_wait), 32'd0);
    chk("b2b_lw_stall1", 32'(core_stall), 32'd1);
    chk("b2b_lw_we1", 32'(mem_we), 32'd0);
    step();
    mem_ready = 1'b1;
    mem_rd    = 32'h55AA55AA;
    @(negedge clk);
    chk("b2b_lw_stall2", 32'(core_stall), 32'd0);
    chk("b2b_lw_rd", core_rd, 32'h55AA55AA);
    step();
    idle_core();
    step();

    // Core dropping its request in WAIT returns to IDLE
    drive(0, 3'd2, 32'h60, 32'h0);
    step();
    core_req = 1'b0;
    @(negedge clk);
    chk("drop_mem_req", 32'(mem_req), 32'd0);
    chk("drop_stall", 32'(core_stall), 32'd0);
    step();
    chk("drop_idle", 32'(dbg_wait), 32'd0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
